// File: rtl/moving_average_filter_if.sv
// Sample stream and filter result bundle between a sample source and moving_average_filter.
// The source drives the master side; the filter sits on the slave side.
interface moving_average_filter_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3
);
    logic                         in_valid;
    logic [DATA_W-1:0]            in_data;
    logic                         avg_en;
    logic                         clear;
    logic                         out_valid;
    logic [DATA_W-1:0]            out_data;
    logic [DATA_W+DEPTH_LOG2-1:0] sum_out;
    logic                         window_full;

    modport master (
        output in_valid, in_data, avg_en, clear,
        input  out_valid, out_data, sum_out, window_full
    );

    modport slave (
        input  in_valid, in_data, avg_en, clear,
        output out_valid, out_data, sum_out, window_full
    );
endinterface

// File: rtl/moving_average_filter.sv
// Boxcar moving-average filter over a 2**DEPTH_LOG2 circular sample window.
// Keeps a running sum and divides by shift; supports bypass, flush and window-full status.
module moving_average_filter #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    moving_average_filter_if.slave       bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int          SUM_W = DATA_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     sample_buf [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      sum_next;

    // The running sum always includes the slot being overwritten, so the subtract cannot underflow.
    always_comb begin
        sum_next = sum + SUM_W'(bus.in_data) - SUM_W'(sample_buf[ptr]);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || bus.clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sample_buf[i] <= '0;
            end
            sum             <= '0;
            ptr             <= '0;
            count           <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.sum_out     <= '0;
            bus.window_full <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                sample_buf[ptr] <= bus.in_data;
                sum             <= sum_next;
                ptr             <= ptr + DEPTH_LOG2'(1);
                if (count != FULL_COUNT) begin
                    count <= count + (DEPTH_LOG2 + 1)'(1);
                end
                bus.out_data <= bus.avg_en ? sum_next[SUM_W-1:DEPTH_LOG2] : bus.in_data;
                bus.sum_out  <= sum_next;
                if (count == FULL_COUNT - (DEPTH_LOG2 + 1)'(1)) begin
                    bus.window_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_moving_average_filter.sv
// Directed plus randomized bench for moving_average_filter against a sample-history reference model.
module tb_moving_average_filter;
    localparam int DW    = 8;
    localparam int DL    = 3;
    localparam int DEPTH = 8;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    moving_average_filter_if #(.DATA_W(DW), .DEPTH_LOG2(DL)) bus ();

    moving_average_filter #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int hist[$];
    int accepted;
    int m_valid, m_data, m_sum, m_full;
    int strobes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int window_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic step(input bit rst, input bit v, input bit clr, input bit avg, input int d);
        logic [31:0] dv;
        dv = d;
        @(negedge CLOCK_50);
        reset        = rst;
        bus.in_valid = v;
        bus.clear    = clr;
        bus.avg_en   = avg;
        bus.in_data  = dv[DW-1:0];
        @(posedge CLOCK_50);
        #1;
        if (rst || clr) begin
            hist.delete();
            accepted = 0;
            m_valid = 0; m_data = 0; m_sum = 0; m_full = 0;
        end else begin
            m_valid = v;
            if (v) begin
                hist.push_back(d);
                if (hist.size() > DEPTH) void'(hist.pop_front());
                accepted++;
                m_sum  = window_sum();
                m_data = avg ? m_sum / DEPTH : d;
                m_full = (accepted >= DEPTH);
            end
        end
        if (bus.out_valid === 1'b1) strobes++;
        check("out_valid",   32'(bus.out_valid),   m_valid);
        check("out_data",    32'(bus.out_data),    m_data);
        check("sum_out",     32'(bus.sum_out),     m_sum);
        check("window_full", 32'(bus.window_full), m_full);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.avg_en   = 1'b1;
        bus.clear    = 1'b0;
        accepted = 0;
        strobes  = 0;

        // 1: constant 80 warm-up ramp
        step(1, 0, 0, 1, 0);
        check("reset_out_data", 32'(bus.out_data), 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 1, 80);
            check("t1_ramp", 32'(bus.out_data), 10 * (i + 1));
        end
        check("t1_sum640", 32'(bus.sum_out), 640);
        step(0, 0, 0, 1, 0);
        check("t1_hold", 32'(bus.out_data), 80);

        // 2: full-scale then zeros
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 255);
        check("t2_max_avg", 32'(bus.out_data), 255);
        check("t2_max_sum", 32'(bus.sum_out), 2040);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
        check("t2_drain", 32'(bus.out_data), 0);

        // 3: ramp with gaps, pointer wraps twice
        step(1, 0, 0, 1, 0);
        strobes = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0, 1, i);
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 1, 0);
        end
        check("t3_strobes", strobes, 20);
        check("t3_sum132", 32'(bus.sum_out), 132);
        check("t3_avg16", 32'(bus.out_data), 16);

        // 4: clear beats a same-cycle sample
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 100);
        step(0, 1, 1, 1, 50);
        check("t4_clr_valid", 32'(bus.out_valid), 0);
        check("t4_clr_full", 32'(bus.window_full), 0);
        check("t4_clr_sum", 32'(bus.sum_out), 0);
        step(0, 1, 0, 1, 40);
        check("t4_after_data", 32'(bus.out_data), 5);
        check("t4_after_sum", 32'(bus.sum_out), 40);

        // 5: bypass keeps the window updating
        step(1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 7);
        step(0, 1, 0, 0, 200);
        check("t5_bypass", 32'(bus.out_data), 200);
        step(0, 1, 0, 0, 13);
        check("t5_sum220", 32'(bus.sum_out), 220);
        step(0, 1, 0, 1, 0);
        check("t5_avg27", 32'(bus.out_data), 27);

        // 6: reset mid-stream
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 64);
        step(1, 1, 0, 1, 64);
        check("t6_rst_sum", 32'(bus.sum_out), 0);
        step(0, 1, 0, 1, 64);
        check("t6_data8", 32'(bus.out_data), 8);
        check("t6_sum64", 32'(bus.sum_out), 64);

        // 7: random traffic
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
